// File: rtl/cpu_pkg.sv
// cpu_pkg: instruction field positions, opcodes and fetch FSM states shared across the CPU
package cpu_pkg;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 27;
  localparam int RS_MSB = 26;
  localparam int RS_LSB = 22;
  localparam int RT_MSB = 21;
  localparam int RT_LSB = 17;
  localparam int RD_MSB = 16;
  localparam int RD_LSB = 12;
  localparam int IMM_MSB = 11;
  localparam int IMM_LSB = 0;
  localparam int IMM_W = 12;
  localparam logic [4:0] OP_JUMP = 5'b10010;
  localparam logic [4:0] OP_BEQ = 5'b10011;
  localparam logic [4:0] OP_BNE = 5'b10100;
  localparam logic [4:0] OP_BLT = 5'b10101;
  localparam logic [4:0] OP_BGT = 5'b10110;
  localparam logic [4:0] OP_BGE = 5'b10111;
  localparam logic [4:0] OP_BLE = 5'b11000;
  typedef enum logic [1:0] {FS_IDLE, FS_WAIT, FS_FAULT} fetch_state_e;
endpackage

// File: rtl/fetch_pc_calc.sv
// fetch_pc_calc: next PC from jump (absolute), taken branch (relative) or sequential, modulo 2^PC_W
module fetch_pc_calc import cpu_pkg::*; #(
  parameter int PC_W = 16
) (
  input  logic [PC_W-1:0]  pc,
  input  logic [IMM_W-1:0] imm,
  input  logic             jump,
  input  logic             branch_taken,
  output logic [PC_W-1:0]  next_pc
);
  assign next_pc = jump ? PC_W'(imm) :
                   branch_taken ? pc + PC_W'(1) + PC_W'($signed(imm)) : pc + PC_W'(1);
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC and instruction register with ready-handshake fetch; FETCH_TIMEOUT_EN adds a sticky fetch watchdog
module fetch_unit import cpu_pkg::*; #(
  parameter int              PC_W           = 16,
  parameter logic [PC_W-1:0] RESET_PC       = '0,
  parameter int              TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_en,
  input  logic            pc_update,
  input  logic            branch_taken,
  input  logic            jump,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instruction,
  output logic            instr_valid,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            fetch_fault
);
  fetch_state_e state, state_nx;
  logic pending, idle, go, done, timeout;
  logic [PC_W-1:0] next_pc;
  assign idle = state == FS_IDLE;
  assign go = idle && (pending || (fetch_en && !pc_update));
  assign imem_req = state == FS_WAIT;
  assign busy = imem_req;
  assign imem_addr = pc;
  assign done = imem_req && imem_ready;
  fetch_pc_calc #(.PC_W(PC_W)) u_pc_calc (
    .pc(pc),
    .imm(instruction[IMM_MSB:IMM_LSB]),
    .jump(jump),
    .branch_taken(branch_taken),
    .next_pc(next_pc)
  );
`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  assign timeout = imem_req && !imem_ready && cnt == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt <= '0;
      fetch_fault <= 1'b0;
    end else begin
      cnt <= go ? '0 : imem_req ? cnt + 1'b1 : cnt;
      if (timeout) fetch_fault <= 1'b1;
    end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
  assign fetch_fault = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= FS_IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (go) state_nx = FS_WAIT;
    else if (done) state_nx = FS_IDLE;
    else if (timeout) state_nx = FS_FAULT;
  end
  // fetch_en together with pc_update is deferred so the fetch uses the updated PC
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pc <= RESET_PC;
      instruction <= '0;
      instr_valid <= 1'b0;
      pending <= 1'b0;
    end else begin
      if (idle && pc_update) pc <= next_pc;
      if (done) instruction <= imem_rdata;
      instr_valid <= (go || (idle && pc_update)) ? 1'b0 : done ? 1'b1 : instr_valid;
      pending <= go ? 1'b0 : pending | (idle && fetch_en && pc_update);
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed plus randomized checks of fetch_unit against a behavioural model
module tb_fetch_unit;
  localparam int TO = 4;
  logic        clk = 0, reset = 0;
  logic        fetch_en = 0, pc_update = 0, branch_taken = 0, jump = 0;
  logic        imem_req, imem_ready = 0;
  logic [15:0] imem_addr, pc;
  logic [31:0] imem_rdata = 0, instruction;
  logic        instr_valid, busy, fetch_fault;
  int n_tests = 0, n_fail = 0;
  logic [15:0] m_pc;
  logic [31:0] m_instr;
  logic        m_valid, m_busy, m_pend, m_fault;
  int          m_cnt;

  fetch_unit #(.PC_W(16), .RESET_PC(16'h0000), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .pc_update(pc_update),
    .branch_taken(branch_taken), .jump(jump), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instruction(instruction),
    .instr_valid(instr_valid), .pc(pc), .busy(busy), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_next(input logic [15:0] p, input logic [11:0] imm,
                                           input logic j, input logic b);
    int s, t;
    s = int'(imm);
    if (s >= 2048) s = s - 4096;
    t = j ? int'(imm) : b ? int'(p) + 1 + s : int'(p) + 1;
    return t[15:0];
  endfunction

  task automatic model_reset();
    m_pc = 16'h0000; m_instr = 0; m_valid = 0; m_busy = 0; m_pend = 0; m_fault = 0; m_cnt = 0;
  endtask

  task automatic check_all();
    check("pc", pc, m_pc);
    check("instruction", instruction, m_instr);
    check("instr_valid", instr_valid, m_valid);
    check("imem_req", imem_req, m_busy);
    check("busy", busy, m_busy);
    check("fetch_fault", fetch_fault, m_fault);
    if (m_busy) check("imem_addr", imem_addr, m_pc);
  endtask

  task automatic cyc(input logic fe, input logic pu, input logic br, input logic jp,
                     input logic rdy, input logic [31:0] rd);
    logic [15:0] n_pc;
    logic [31:0] n_instr;
    logic n_valid, n_busy, n_pend, n_fault;
    int n_cnt;
    fetch_en = fe; pc_update = pu; branch_taken = br; jump = jp; imem_ready = rdy; imem_rdata = rd;
    n_pc = m_pc; n_instr = m_instr; n_valid = m_valid; n_busy = m_busy;
    n_pend = m_pend; n_fault = m_fault; n_cnt = m_cnt;
    if (!m_busy && !m_fault) begin
      if (pu) begin n_pc = ref_next(m_pc, m_instr[11:0], jp, br); n_valid = 0; end
      if (m_pend || (fe && !pu)) begin n_busy = 1; n_valid = 0; n_pend = 0; n_cnt = 0; end
      else if (fe && pu) n_pend = 1;
    end else if (m_busy) begin
      if (rdy) begin n_busy = 0; n_instr = rd; n_valid = 1; end
`ifdef FETCH_TIMEOUT_EN
      else if (m_cnt + 1 == TO) begin n_busy = 0; n_fault = 1; end
      else n_cnt = m_cnt + 1;
`endif
    end
    @(posedge clk);
    m_pc = n_pc; m_instr = n_instr; m_valid = n_valid; m_busy = n_busy;
    m_pend = n_pend; m_fault = n_fault; m_cnt = n_cnt;
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 0;
    fetch_en = 0; pc_update = 0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    reset = 1;
  endtask

  task automatic fetch(input logic [31:0] w);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, w);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset = 1;
    // first fetch with ready tied high: minimum latency
    cyc(1, 0, 0, 0, 1, 32'hCAFE_0001);
    check("first_req", imem_req, 1);
    check("first_addr", imem_addr, 16'h0000);
    cyc(0, 0, 0, 0, 1, 32'h1234_5010);
    check("first_instr", instruction, 32'h1234_5010);
    check("first_valid", instr_valid, 1);
    // ready delayed by three cycles
    cyc(0, 1, 0, 1, 1, 0);
    check("jump_pc_10", pc, 16'h0010);
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0, 32'hDEAD_0000 + i);
      check("slow_busy", busy, 1);
      check("slow_addr", imem_addr, 16'h0010);
      check("slow_nolatch", instruction, 32'h1234_5010);
    end
    cyc(0, 0, 0, 0, 1, 32'hAB00_0FFE);
    check("slow_instr", instruction, 32'hAB00_0FFE);
    check("slow_busy_done", busy, 0);
    cyc(0, 1, 1, 0, 0, 0);
    check("branch_back", pc, 16'h000F);
    fetch(32'h0000_0003);
    cyc(0, 1, 1, 1, 0, 0);
    check("jump_prio", pc, 16'h0003);
    fetch(32'h0000_0010);
    cyc(0, 1, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    check("seq_pc", pc, 16'h0011);
    fetch(32'h0000_0FFF);
    cyc(0, 1, 0, 1, 0, 0);
    check("jump_fff", pc, 16'h0FFF);
    do_reset();
    fetch(32'h0000_0FFE);
    cyc(0, 1, 1, 0, 0, 0);
    check("branch_neg_wrap", pc, 16'hFFFF);
    cyc(0, 1, 0, 0, 0, 0);
    check("seq_wrap", pc, 16'h0000);
    // fetch_en together with pc_update defers the fetch
    cyc(1, 1, 0, 0, 0, 0);
    check("defer_pc", pc, 16'h0001);
    check("defer_noreq", imem_req, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("defer_req", imem_req, 1);
    check("defer_addr", imem_addr, 16'h0001);
    cyc(0, 1, 0, 1, 0, 0);
    check("wait_ignore_pu", pc, 16'h0001);
    // reset mid-fetch, then a stray ready in IDLE
    do_reset();
    cyc(0, 0, 0, 0, 1, 32'h5555_AAAA);
    check("stray_ready_instr", instruction, 0);
    check("stray_ready_valid", instr_valid, 0);
`ifdef FETCH_TIMEOUT_EN
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < TO; i++) cyc(0, 0, 0, 0, 0, 0);
    check("to_fault", fetch_fault, 1);
    check("to_req", imem_req, 0);
    cyc(1, 1, 0, 0, 1, 32'h1111_2222);
    check("to_hold", fetch_fault, 1);
    do_reset();
`endif
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0 || (m_fault && $urandom_range(0, 9) == 0)) do_reset();
      cyc($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3, $urandom_range(0, 1) == 1,
          $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, $urandom);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of `Control_Unit`. It holds the program counter and requests instruction words from instruction memory through a ready-based handshake. It latches each fetched word into an instruction register that drives `Control_Unit.instruction`, and it applies the control unit's `branch_taken`/`Jump` decision to compute the next PC at the end of every instruction.

## Interface
Parameters:
- `PC_W`, default 16: program counter width. The PC is a word address.
- `RESET_PC`, default 0: PC value loaded on reset.
- `TIMEOUT_CYCLES`, default 255: fetch watchdog limit. Used only when `FETCH_TIMEOUT_EN` is defined.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset; asserted when 0.
- `fetch_en`  in  1  single-cycle strobe from the control unit on entering FETCH.
- `pc_update`  in  1  single-cycle strobe at the end of an instruction; applies the next PC.
- `branch_taken`  in  1  branch decision from `Control_Unit`, sampled with `pc_update`.
- `jump`  in  1  jump decision from `Control_Unit`, sampled with `pc_update`.
- `imem_req`  out  1  memory read request; registered.
- `imem_addr`  out  PC_W  read address; equals `pc` while `imem_req`=1.
- `imem_ready`  in  1  memory returns `imem_rdata` this cycle.
- `imem_rdata`  in  32  instruction word from memory.
- `instruction`  out  32  instruction register, fed to `Control_Unit`.
- `instr_valid`  out  1  `instruction` holds the word fetched for the current `pc`.
- `pc`  out  PC_W  current program counter.
- `busy`  out  1  fetch in progress (state WAIT).
- `fetch_fault`  out  1  sticky watchdog error.

## Operation
- Instruction fields: opcode[31:27], rs[26:22], rt[21:17], rd[16:12], imm[11:0].
- FSM states:
  - IDLE: no fetch in progress.
  - WAIT: `imem_req`=1, waiting for `imem_ready`.
  - FAULT: exists only with `FETCH_TIMEOUT_EN`.
- IDLE to WAIT on `fetch_en`. On the same edge, `instr_valid` is cleared.
- WAIT to IDLE on `imem_ready`. On that edge, `instruction` <= `imem_rdata`, `instr_valid` <= 1, and `imem_req` <= 0.
- Next-PC calculation, evaluated on `pc_update` in IDLE using `instruction.imm`. Priority order:
  - `jump`: PC = zero-extended imm.
  - else `branch_taken`: PC = `pc` + 1 + sign-extended imm.
  - else: PC = `pc` + 1.
  - All results are modulo 2^PC_W; wrap-around is silent (0xFFFF + 1 = 0x0000).
- `pc_update` clears `instr_valid`.
- `pc_update` received in WAIT is ignored. `fetch_en` received in WAIT is ignored.
- `fetch_en` and `pc_update` in the same IDLE cycle:
  - The PC updates on that edge.
  - The fetch is held in a one-bit pending flag and starts on the next edge at the new PC.
- Reset, at any time including mid-fetch:
  - `pc`=RESET_PC, `instruction`=0, `instr_valid`=0, `imem_req`=0, `busy`=0, `fetch_fault`=0, state IDLE, pending flag cleared.
  - An `imem_ready` arriving after reset while in IDLE is ignored.

## Timing
- `fetch_en` is sampled at edge N. `imem_req` and `busy` go high after N.
- The earliest `imem_ready` is sampled at edge N+1. `instruction` and `instr_valid` are visible after N+1, giving a minimum latency of 2 cycles.
- Each cycle of `imem_ready` delay adds one cycle of latency.
- `imem_addr` is stable for the whole time `imem_req` is high.
- `pc_update` sampled at edge M makes the new `pc` visible after M.
- A deferred fetch raises `imem_req` after M+1.

## Configuration
- `FETCH_TIMEOUT_EN` defined:
  - In WAIT, a counter increments every cycle.
  - If it reaches TIMEOUT_CYCLES without `imem_ready`: `fetch_fault` <= 1, `imem_req` <= 0, state goes to FAULT.
  - FAULT is exited only by reset.
  - The counter clears on entering WAIT.
- `FETCH_TIMEOUT_EN` undefined:
  - No counter and no FAULT state.
  - `fetch_fault` is tied to 0.
  - WAIT lasts indefinitely.

## Structure
- Shared package `cpu_pkg`:
  - Instruction field MSB/LSB constants and `IMM_W`=12.
  - Opcode constants: JUMP=5'b10010; BEQ through BLE = 5'b10011 to 5'b11000.
  - Fetch FSM state enumeration.
- One combinational sub-module, `fetch_pc_calc`: inputs `pc`, imm, `jump`, `branch_taken`; output next PC.

## Test plan
- Reset released with `imem_ready` tied high; `fetch_en` pulse at edge 1 -> `imem_req`=1 with `imem_addr`=0 after edge 1. `instruction`=`imem_rdata` and `instr_valid`=1 after edge 2.
- `imem_ready` delayed by 3 cycles -> `imem_addr` stable, `busy`=1 for 4 cycles, `instruction` latched only on the ready edge.
- `pc`=0x0010 with imm=0xFFE and `branch_taken`=1 -> `pc`=0x000F. With `jump`=1 and imm=0x003 -> `pc`=0x0003. With neither -> `pc`=0x0011. With `pc`=0xFFFF, sequential -> `pc`=0x0000.
- `fetch_en` and `pc_update` in the same cycle -> `pc` updates first, then `imem_req` rises one cycle later at the new address.
- Reset asserted in WAIT, then `imem_ready` pulsed -> all outputs at reset values; `instruction` stays 0.
- With `FETCH_TIMEOUT_EN` and TIMEOUT_CYCLES=4, `imem_ready` held low -> `fetch_fault`=1 and `imem_req`=0 after 4 WAIT cycles; both hold until reset.
